// File: rtl/unsquish_pkg.sv
// Shared types and widths for the bit-pair expander on the XOR-network datapath.
package unsquish_pkg;

  localparam int PAIRS_DEF = 16;
  localparam int LANES_DEF = 4;
  localparam int PACKED_W  = 17;
  localparam int WIDE_W    = 33;

  typedef enum logic [1:0] {
    FILL_LO   = 2'b00,
    FILL_HI   = 2'b01,
    FILL_BOTH = 2'b10
  } mode_e;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DONE
  } state_e;

endpackage

// File: rtl/unsquish_expander_if.sv
// Handshake bundle between the activation stage, the expander and the MAC input register.
interface unsquish_expander_if #(
  parameter int PAIRS = unsquish_pkg::PAIRS_DEF
);
  logic             in_valid;
  logic             in_ready;
  logic [PAIRS:0]   in_data;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [2*PAIRS:0] out_data;
  logic             busy;

  modport slave (
    input  in_valid, in_data, mode, out_ready,
    output in_ready, out_valid, out_data, busy
  );

  modport master (
    output in_valid, in_data, mode, out_ready,
    input  in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/unsquish_lane.sv
// One pair-flag expanded to its 2-bit fill pattern; mode 11 is reserved and fills like 10.
module unsquish_lane
  import unsquish_pkg::*;
(
  input  logic       flag_i,
  input  logic [1:0] mode_i,
  output logic [1:0] pair_o
);

  always_comb begin
    pair_o = 2'b00;
    if (flag_i) begin
      case (mode_i)
        FILL_LO: pair_o = 2'b01;
        FILL_HI: pair_o = 2'b10;
        default: pair_o = 2'b11;
      endcase
    end
  end

endmodule

// File: rtl/unsquish_expander.sv
// Serial pair-flag expander: LANES flags per cycle into a 2*PAIRS+1 bit word.
// Optional macro UNSQUISH_ZERO_SKIP_EN ends EXPAND early once no set flags remain.
//
//   state  | meaning
//   IDLE   | in_ready high, waiting for a packed word
//   EXPAND | LANES flags per cycle written into out_data
//   DONE   | out_valid high, out_data held until out_ready
module unsquish_expander
  import unsquish_pkg::*;
#(
  parameter int PAIRS = PAIRS_DEF,
  parameter int LANES = LANES_DEF
) (
  input logic                clk,
  input logic                rst_n,
  unsquish_expander_if.slave bus
);

  localparam int STEPS = PAIRS / LANES;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  state_e                state_q, state_d;
  logic [PAIRS-1:0]      sr_q, sr_d;
  logic [1:0]            mode_q, mode_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2*PAIRS:0]      out_q, out_d;
  logic [LANES-1:0][1:0] lane_pair;
  logic [2*PAIRS-1:0]    lane_ext;
  logic                  last_step;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    unsquish_lane u_lane (
      .flag_i (sr_q[i]),
      .mode_i (mode_q),
      .pair_o (lane_pair[i])
    );
  end

  always_comb begin
    lane_ext                = '0;
    lane_ext[2*LANES-1:0]   = lane_pair;
  end

`ifdef UNSQUISH_ZERO_SKIP_EN
  // Flags still to come are all clear, so the remaining magnitude bits are already zero.
  assign last_step = (cnt_q == CNT_W'(STEPS - 1)) || ((sr_q >> LANES) == '0);
`else
  assign last_step = (cnt_q == CNT_W'(STEPS - 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      mode_q  <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sr_d    = bus.in_data[PAIRS-1:0];
          mode_d  = bus.mode;
          out_d   = {bus.in_data[PAIRS], {(2*PAIRS){1'b0}}};
          cnt_d   = '0;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        out_d[2*PAIRS-1:0] = out_q[2*PAIRS-1:0] | (lane_ext << (2 * LANES * int'(cnt_q)));
        sr_d  = sr_q >> LANES;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_step) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_data  = out_q;

endmodule

// File: tb/tb_unsquish_expander.sv
// Directed plus random transfers through unsquish_expander, checked against a flag-by-flag model.
module tb_unsquish_expander;
  import unsquish_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  unsquish_expander_if #(.PAIRS(16)) bus ();

  unsquish_expander #(.PAIRS(16), .LANES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDE_W-1:0] model_expand(input logic [PACKED_W-1:0] d, input logic [1:0] m);
    logic [WIDE_W-1:0] r;
    longint unsigned   fill;
    fill = (m == 2'd0) ? 1 : (m == 2'd1) ? 2 : 3;
    r    = '0;
    r[32] = d[16];
    for (int k = 0; k < 16; k++)
      if (d[k]) r = r | WIDE_W'(fill << (2 * k));
    return r;
  endfunction

  function automatic int model_cycles(input logic [15:0] flags);
`ifdef UNSQUISH_ZERO_SKIP_EN
    for (int c = 1; c <= 4; c++)
      if ((32'(flags) >> (4 * c)) == 0) return c;
    return 4;
`else
    return 4 + 0 * int'(flags);
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic [16:0] d, input logic [1:0] m, input logic [32:0] exp, input int hold);
    int n;
    bit got;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.mode     = m;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", 64'(n < 50), 64'd1);
    @(posedge clk);
    #1;
    // keep in_valid high with junk: must be ignored outside IDLE
    bus.in_data = 17'($urandom);
    bus.mode    = 2'($urandom);
    check("busy_after_accept", 64'(bus.busy), 64'd1);
    check("in_ready_expand", 64'(bus.in_ready), 64'd0);
    n   = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      bus.out_ready = 1'($urandom);
      @(posedge clk);
      #1;
      n++;
      got = bus.out_valid;
    end
    bus.out_ready = (hold == 0);
    check("latency", 64'(n), 64'(model_cycles(d[15:0])));
    check("out_data", 64'(bus.out_data), 64'(exp));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", 64'(bus.out_valid), 64'd1);
      check("hold_data", 64'(bus.out_data), 64'(exp));
      check("hold_in_ready", 64'(bus.in_ready), 64'd0);
      if (i == hold - 1) bus.out_ready = 1'b1;
    end
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("release_valid", 64'(bus.out_valid), 64'd0);
    check("release_in_ready", 64'(bus.in_ready), 64'd1);
    check("release_busy", 64'(bus.busy), 64'd0);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [16:0] rd;
    logic [1:0]  rm;
    bit          seen;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.mode      = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);

    xfer(17'h0_0001, 2'b10, 33'h0_0000_0003, 0);
    xfer(17'h1_8000, 2'b01, 33'h1_8000_0000, 1);
    xfer(17'h1_8000, 2'b00, 33'h1_4000_0000, 0);
    xfer(17'h1_8000, 2'b11, 33'h1_C000_0000, 2);
    xfer(17'h0_FFFF, 2'b10, 33'h0_FFFF_FFFF, 10);
    xfer(17'h0_5555, 2'b01, 33'h0_2222_2222, 0);
    xfer(17'h0_AAAA, 2'b01, 33'h0_8888_8888, 0);
    xfer(17'h1_0000, 2'b10, 33'h1_0000_0000, 0);
    xfer(17'h0_000F, 2'b10, 33'h0_0000_00FF, 0);

    // reset during the second EXPAND cycle discards the word
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 17'h0_FFFF;
    bus.mode     = 2'b10;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_out_data", 64'(bus.out_data), 64'd0);
    check("midrst_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen = 1'b1;
    end
    check("midrst_no_valid", 64'(seen), 64'd0);
    check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    check("midrst_data_zero", 64'(bus.out_data), 64'd0);

    for (int t = 0; t < 24; t++) begin
      rd = 17'($urandom);
      if (t % 4 == 0) rd[15:0] = rd[15:0] & 16'h00FF;
      rm = 2'($urandom);
      xfer(rd, rm, model_expand(rd, rm), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
